pre_load_bram_streamer: RTL
===========================

// Module: pre_load_bram_streamer
// PURPOSE
//  Boot-time image loader: reads a byte-wide pre-initialised ROM (fixed read latency 1) and streams the image
//  into on-chip SRAM as 32-bit little-endian writes on an OBI-style master port (req/gnt/rvalid).
//  Generalises the single byte ROM into a sized, addressed, restartable loader with partial-word tail handling.
//  Sits between the boot ROM primitive and the system bus; busy_o holds the core in reset until the copy ends.
// PARAMETERS
//  NUM_BYTES     100000        image length in bytes (>=1)
//  ROM_AW        17            ROM byte-address width; 2**ROM_AW >= NUM_BYTES
//  BUS_AW        32            bus address width
//  BASE_ADDR     32'h0000_0000 SRAM destination of image byte 0; word aligned
// PORTS
//  clk_i           in   1        clock, all logic on rising edge
//  rst_i           in   1        asynchronous, active-high reset
//  start_i         in   1        1-cycle pulse: begin copy (ignored while busy_o=1)
//  rom_en_o        out  1        ROM read enable
//  rom_addr_o      out  ROM_AW   ROM byte address
//  rom_data_i      in   8        ROM data, valid 1 cycle after rom_en_o
//  bus_req_o       out  1        OBI request
//  bus_we_o        out  1        write enable (1 whenever bus_req_o=1)
//  bus_be_o        out  4        byte enables
//  bus_addr_o      out  BUS_AW   word address
//  bus_wdata_o     out  32       write data
//  bus_gnt_i       in   1        OBI grant
//  bus_rvalid_i    in   1        OBI response valid (write completion)
//  busy_o          out  1        copy in progress
//  done_o          out  1        sticky: image fully written; cleared by next accepted start_i
//  words_o         out  ROM_AW-1 count of completed word writes
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; rd_ptr=0; words_o=0. Reset mid-copy aborts immediately, no bus cleanup.
//  FSM IDLE -> FETCH on start_i (clears done_o, rd_ptr, words_o; busy_o=1 from next cycle).
//  FETCH: nb = min(4, NUM_BYTES-word_start). Issue nb consecutive cycles rom_en_o=1, rom_addr_o=rd_ptr++.
//    Byte returned one cycle after each issue goes to lane (addr mod 4); lanes >= nb zeroed.
//    After last byte captured (nb+1 cycles after FETCH entry) -> WRITE.
//  WRITE: bus_req_o=1, bus_we_o=1, bus_addr_o=BASE_ADDR+4*words_o, bus_wdata_o=assembled word,
//    bus_be_o = (1<<nb)-1 (4'hF for full words). All held stable until bus_gnt_i=1 sampled -> RESP.
//  RESP: bus_req_o=0; wait bus_rvalid_i; then words_o++; rd_ptr==NUM_BYTES ? DONE : FETCH.
//    rvalid in the same cycle as gnt is not possible per OBI; rvalid earliest the cycle after gnt.
//  DONE: busy_o=0, done_o=1 (registered, same cycle as busy_o fall) -> IDLE.
//  One outstanding bus transaction max; rom_en_o=0 outside FETCH; bus_req_o=0 outside WRITE.
//  start_i while busy_o=1: ignored, no effect on counters. start_i in DONE/IDLE after completion: restart.
//  Latency per full word, zero-wait bus: 5 (FETCH) + 1 (WRITE) + 1 (RESP) = 7 cycles.
//  rd_ptr/words_o never wrap: NUM_BYTES bound checked at elaboration ($error if 2**ROM_AW < NUM_BYTES).
// TESTING
//  T1 NUM_BYTES=8, ROM=00..07, gnt/rvalid zero-wait -> writes @BASE wdata 03020100 be F, @BASE+4
//     wdata 07060504 be F; done_o=1, words_o=2, 14 cycles start->done rise.
//  T2 NUM_BYTES=6, same ROM -> second write wdata 00000504 be 4'b0011; rom_en_o pulses total 6.
//  T3 gnt delayed 3 cycles, rvalid delayed 2 -> req/addr/wdata/be stable until gnt; no new rom_en_o
//     before rvalid; final data identical to T1.
//  T4 start_i pulsed mid-copy -> ignored (words_o continues, no restart); start_i after done -> done_o
//     clears, words_o=0, image rewritten identically.
//  T5 rst_i asserted while bus_req_o=1 -> asynchronously all outputs 0; after release, idle until start_i.
//  T6 NUM_BYTES=1, ROM[0]=A5 -> one write wdata 000000A5 be 4'b0001, words_o=1.

Source files
------------

// File: rtl/pre_load_bram_streamer.sv
// Boot-time image loader: copies a byte-wide ROM (read latency 1) into SRAM
// as 32-bit little-endian OBI writes, with partial-word handling on the tail.
module pre_load_bram_streamer #(
  parameter int unsigned       NUM_BYTES = 100000,
  parameter int unsigned       ROM_AW    = 17,
  parameter int unsigned       BUS_AW    = 32,
  parameter logic [BUS_AW-1:0] BASE_ADDR = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              rom_en_o,
  output logic [ROM_AW-1:0] rom_addr_o,
  input  logic [7:0]        rom_data_i,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_be_o,
  output logic [BUS_AW-1:0] bus_addr_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ROM_AW-2:0] words_o
);

  // The read pointer carries one extra bit so it can reach NUM_BYTES == 2**ROM_AW.
  localparam logic [ROM_AW:0] END_PTR = (ROM_AW+1)'(NUM_BYTES);

  if ((2**ROM_AW) < NUM_BYTES) begin : g_bad_rom_aw
    $error("pre_load_bram_streamer: ROM_AW too small for NUM_BYTES");
  end
  if (NUM_BYTES < 1) begin : g_bad_num_bytes
    $error("pre_load_bram_streamer: NUM_BYTES must be at least 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WRITE = 3'd2,
    ST_RESP  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t            state_r;
  logic [ROM_AW:0]   rd_ptr_r;
  logic [2:0]        nb_r;        // bytes in the current word (1..4)
  logic [2:0]        issued_r;    // ROM reads issued for the current word
  logic [2:0]        capt_r;      // ROM bytes captured for the current word
  logic              rom_en_d_r;  // rom_en_o delayed: rom_data_i valid this cycle
  logic [1:0]        lane_d_r;    // byte lane of the read in flight

  logic              start_ok_s;
  logic              enter_fetch_s;
  logic [ROM_AW:0]   entry_ptr_s;
  logic [2:0]        entry_nb_s;

  // Bytes left in the image from ptr, saturated at one word.
  function automatic logic [2:0] calc_nb(input logic [ROM_AW:0] ptr);
    logic [ROM_AW:0] rem;
    rem = END_PTR - ptr;
    if (|rem[ROM_AW:2]) begin
      return 3'd4;
    end else begin
      return rem[2:0];
    end
  endfunction

  // Byte enables for a word carrying nb valid low-order bytes.
  function automatic logic [3:0] be_of(input logic [2:0] nb);
    return 4'((5'd1 << nb) - 5'd1);
  endfunction

  // Decide when a new word fetch begins and where it starts in the ROM.
  always_comb begin
    start_ok_s    = start_i && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    enter_fetch_s = start_ok_s ||
                    ((state_r == ST_RESP) && bus_rvalid_i && (rd_ptr_r != END_PTR));
    if (start_ok_s) begin
      entry_ptr_s = {(ROM_AW+1){1'b0}};
    end else begin
      entry_ptr_s = rd_ptr_r;
    end
    entry_nb_s = calc_nb(entry_ptr_s);
  end

  // Copy sequencer: ROM fetch, word assembly, one outstanding bus write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      rd_ptr_r    <= {(ROM_AW+1){1'b0}};
      nb_r        <= 3'd0;
      issued_r    <= 3'd0;
      capt_r      <= 3'd0;
      rom_en_d_r  <= 1'b0;
      lane_d_r    <= 2'd0;
      rom_en_o    <= 1'b0;
      rom_addr_o  <= {ROM_AW{1'b0}};
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_be_o    <= 4'h0;
      bus_addr_o  <= {BUS_AW{1'b0}};
      bus_wdata_o <= 32'h0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      words_o     <= {(ROM_AW-1){1'b0}};
    end else begin
      rom_en_d_r <= rom_en_o;
      lane_d_r   <= rom_addr_o[1:0];
      case (state_r)
        ST_IDLE, ST_DONE: begin
          state_r <= ST_IDLE;
          if (start_ok_s) begin
            done_o  <= 1'b0;
            words_o <= {(ROM_AW-1){1'b0}};
          end
        end
        ST_FETCH: begin
          if (issued_r < nb_r) begin
            rom_en_o   <= 1'b1;
            rom_addr_o <= rd_ptr_r[ROM_AW-1:0];
            rd_ptr_r   <= rd_ptr_r + (ROM_AW+1)'(1);
            issued_r   <= issued_r + 3'd1;
          end else begin
            rom_en_o <= 1'b0;
          end
          if (rom_en_d_r) begin
            bus_wdata_o[{lane_d_r, 3'b000} +: 8] <= rom_data_i;
            capt_r <= capt_r + 3'd1;
            if ((capt_r + 3'd1) == nb_r) begin
              state_r    <= ST_WRITE;
              bus_req_o  <= 1'b1;
              bus_we_o   <= 1'b1;
              bus_be_o   <= be_of(nb_r);
              bus_addr_o <= BASE_ADDR + BUS_AW'({words_o, 2'b00});
            end
          end
        end
        ST_WRITE: begin
          if (bus_gnt_i) begin
            state_r   <= ST_RESP;
            bus_req_o <= 1'b0;
            bus_we_o  <= 1'b0;
          end
        end
        ST_RESP: begin
          if (bus_rvalid_i) begin
            words_o <= words_o + (ROM_AW-1)'(1);
            if (rd_ptr_r == END_PTR) begin
              state_r <= ST_DONE;
              busy_o  <= 1'b0;
              done_o  <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
      // Word fetch entry: first ROM read issues in the first FETCH cycle.
      if (enter_fetch_s) begin
        state_r     <= ST_FETCH;
        busy_o      <= 1'b1;
        rom_en_o    <= 1'b1;
        rom_addr_o  <= entry_ptr_s[ROM_AW-1:0];
        rd_ptr_r    <= entry_ptr_s + (ROM_AW+1)'(1);
        issued_r    <= 3'd1;
        capt_r      <= 3'd0;
        nb_r        <= entry_nb_s;
        bus_wdata_o <= 32'h0;
      end
    end
  end

endmodule
